spi_master_tx: RTL

//  - SPI initiator (mode 0, MSB first): FPGA drives SCK/CS/MOSI, samples MISO; the initiator end of the samd51<->ice40 link.
//  - Intended for the alternate port pins (pa19-pa22) to talk to the MCU or an external SPI peripheral.
//  - Word-level valid/ready request in; received word plus 1-cycle strobe out. Runs on the 48 MHz HFOSC clock.

---
 rtl/doppler_spi_pkg.sv | 23 ++
 rtl/spi_sync2.sv | 31 +++
 rtl/spi_master_tx.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/doppler_spi_pkg.sv
// Shared definitions for the doppler SPI link: FSM state encodings,
// SPI mode constants and clock-divider defaults for the 48 MHz HFOSC.
package doppler_spi_pkg;

  // Transfer sequencing: IDLE -> SETUP -> XFER -> HOLD -> GAP -> IDLE
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_XFER  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } spi_state_e;

  // SPI mode 0: SCK idles low, data sampled on the rising edge
  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

  // 48 MHz / (2 * 12) = 2 MHz SCK
  localparam int DEFAULT_CLK_DIV = 12;
  localparam int DEFAULT_WORD_W  = 16;
  localparam int DEFAULT_CS_GAP  = 4;

endpackage

// File: rtl/spi_sync2.sv
// Two-flop synchroniser for a single asynchronous input, flops reset to 0.
module spi_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic q_out
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // next-state of the synchroniser chain
  always_comb begin
    meta_d = d_in;
    sync_d = meta_q;
  end

  // chain registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_out = sync_q;

endmodule

// File: rtl/spi_master_tx.sv
// SPI initiator, mode 0, MSB first. One word per valid/ready handshake;
// the received word is presented with a 1-cycle rx_valid strobe when
// chip select is released.
// Optional macro SPI_MASTER_BURST_EN: accept the next word in the last
// HOLD cycle and chain it without releasing chip select.
module spi_master_tx
  import doppler_spi_pkg::*;
#(
  parameter int WORD_W  = DEFAULT_WORD_W,
  parameter int CLK_DIV = DEFAULT_CLK_DIV,
  parameter int CS_GAP  = DEFAULT_CS_GAP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [WORD_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              spi_sck,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic              spi_cs_n
);

  localparam int DIV_W  = $clog2(CLK_DIV);
  localparam int HALF_W = $clog2(2 * WORD_W + 1);
  localparam int GAP_W  = $clog2(CS_GAP + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * WORD_W - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(CS_GAP - 1);

  spi_state_e        state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [HALF_W-1:0] half_q, half_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [WORD_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              sck_q, sck_d;
  logic              cs_n_q, cs_n_d;
  logic              mosi_q, mosi_d;

  logic              miso_s;
  logic [WORD_W-1:0] shift_in;
  logic              div_last;
  logic              hold_done;
  logic              burst_ready;
  logic              accept;

  spi_sync2 u_miso_sync (
    .clk   (clk),
    .rst   (rst),
    .d_in  (spi_miso),
    .q_out (miso_s)
  );

  // One shift register serves both directions: the outgoing MSB leaves at
  // each falling edge while the sampled MISO bit enters at the LSB.
  assign shift_in  = (shift_q << 1) | WORD_W'(miso_s);
  assign div_last  = (div_q == DIV_LAST);
  assign hold_done = (state_q == ST_HOLD) && div_last;

`ifdef SPI_MASTER_BURST_EN
  assign burst_ready = hold_done;
`else
  assign burst_ready = 1'b0;
`endif

  assign tx_ready = !rst && ((state_q == ST_IDLE) || burst_ready);
  assign accept   = tx_valid && tx_ready;

  // next-state and output logic for the transfer FSM
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    half_d     = half_q;
    gap_d      = gap_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    sck_d      = sck_q;
    cs_n_d     = cs_n_q;
    mosi_d     = mosi_q;
    case (state_q)
      ST_IDLE: begin
        div_d  = '0;
        half_d = '0;
        gap_d  = '0;
        if (accept) begin
          state_d = ST_SETUP;
          shift_d = tx_data;
          cs_n_d  = 1'b0;
          mosi_d  = tx_data[WORD_W-1];
        end
      end
      ST_SETUP: begin
        if (div_last) begin
          div_d   = '0;
          half_d  = '0;
          sck_d   = ~SPI_CPOL;
          state_d = ST_XFER;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      ST_XFER: begin
        if (div_last) begin
          div_d = '0;
          // leaving a high half-period: sample MISO and advance MOSI
          if (sck_q) begin
            shift_d = shift_in;
            mosi_d  = shift_in[WORD_W-1];
          end
          if (half_q == HALF_LAST) begin
            state_d = ST_HOLD;
            sck_d   = SPI_CPOL;
            mosi_d  = 1'b0;
          end else begin
            half_d = half_q + HALF_W'(1);
            sck_d  = ~sck_q;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      ST_HOLD: begin
        if (div_last) begin
          div_d      = '0;
          rx_data_d  = shift_q;
          rx_valid_d = 1'b1;
          if (accept) begin
            // chained word: chip select stays asserted
            state_d = ST_SETUP;
            shift_d = tx_data;
            mosi_d  = tx_data[WORD_W-1];
          end else begin
            state_d = ST_GAP;
            cs_n_d  = 1'b1;
            gap_d   = '0;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cs_n_d  = 1'b1;
        sck_d   = SPI_CPOL;
        mosi_d  = 1'b0;
      end
    endcase
  end

  // state and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      div_q      <= '0;
      half_q     <= '0;
      gap_q      <= '0;
      shift_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      sck_q      <= SPI_CPOL;
      cs_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      half_q     <= half_d;
      gap_q      <= gap_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      sck_q      <= sck_d;
      cs_n_q     <= cs_n_d;
      mosi_q     <= mosi_d;
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = (state_q != ST_IDLE);
  assign spi_sck  = sck_q;
  assign spi_cs_n = cs_n_q;
  assign spi_mosi = mosi_q;

endmodule
